// File: rtl/ext_mem_arbiter_pkg.sv
// Shared encodings and constants for the external memory arbiter.
package ext_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Width of the access timeout counter; TIMEOUT must fit in 1..31.
    localparam int TCNT_W = 5;

endpackage

// File: rtl/ext_mem_arbiter_rr_pick2.sv
// Combinational two-way winner select: round-robin or fixed priority to port 0.
module rr_pick2
    import ext_mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic any,
    output logic winner
);

    always_comb begin
        any    = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            // On a tie the round-robin case hands the grant to the port served less recently.
            winner = (FIXED_PRI != 0) ? PORT_CPU : ~last_gnt;
        end else if (req1) begin
            winner = PORT_AUX;
        end
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Two-port arbiter/sequencer sharing one external SRAM controller between CPU and an aux master.
module ext_mem_arbiter
    import ext_mem_arbiter_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 20,
    parameter int FIXED_PRI = 0,
    parameter int TIMEOUT   = 31
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             rnw0,
    input  logic             rnw1,
    input  logic [ASIZE-1:0] addr0,
    input  logic [ASIZE-1:0] addr1,
    input  logic [DSIZE-1:0] wdata0,
    input  logic [DSIZE-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic [DSIZE-1:0] rdata,
    output logic             gnt,
    output logic             busy,
    output logic             mc_cs_b,
    output logic             mc_rnw,
    output logic [ASIZE-1:0] mc_addr,
    output logic [DSIZE-1:0] mc_wdata,
    input  logic [DSIZE-1:0] mc_rdata,
    input  logic             mc_clken
);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [TCNT_W-1:0]   tcnt;
    logic                last_gnt;
    logic                any_req;
    logic                winner;
    logic                grant;
    logic                complete;
    logic                timeout;

    rr_pick2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .any      (any_req),
        .winner   (winner)
    );

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Controller completion outranks a timeout landing on the same edge.
                if (mc_clken) begin
                    complete  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (tcnt == TCNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mc_cs_b  <= 1'b1;
            mc_rnw   <= 1'b1;
            mc_addr  <= '0;
            mc_wdata <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            gnt      <= PORT_CPU;
            last_gnt <= PORT_AUX;
            busy     <= 1'b0;
            tcnt     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            busy <= (state_nxt != ST_IDLE);

            if (grant) begin
                mc_cs_b  <= 1'b0;
                mc_rnw   <= winner ? rnw1   : rnw0;
                mc_addr  <= winner ? addr1  : addr0;
                mc_wdata <= winner ? wdata1 : wdata0;
                gnt      <= winner;
                last_gnt <= winner;
                tcnt     <= '0;
            end else if (state == ST_ACCESS && tcnt != '1) begin
                tcnt <= tcnt + 1'b1;
            end

            // The acknowledge is registered here so it is high during DONE.
            if (complete || timeout) begin
                mc_cs_b <= 1'b1;
                err     <= timeout;
                ack0    <= (gnt == PORT_CPU);
                ack1    <= (gnt == PORT_AUX);
            end

            if (complete && mc_rnw) begin
                rdata <= mc_rdata;
            end
        end
    end

endmodule
